cbadc_modulator_fix: RTL and testbench
======================================

// Module: cbadc_modulator_fix
// PURPOSE
//  Bit-true fixed-point model of the chain-of-integrators control-bounded ADC front end.
//  Produces the N-bit control vector that the hybrid fixed-point CB filter consumes on its in[N-1:0] port.
//  Takes a sample-streamed input u and applies a zero-order hold of HOLD clk cycles to each sample.
//  Used as the on-chip/FPGA stimulus source and as the loop-back transmitter for filter verification.
// PARAMETERS
//  N          3   number of integrators = number of control bits
//  n_int      9   integer bits of integrator state (plus sign)
//  n_mant     15  fractional bits of state and of u_in; full scale 1.0 = 2^n_mant
//  BETA_SHIFT 3   integrator gain beta = 2^-BETA_SHIFT, applied as an arithmetic right shift
//  HOLD       12  clk cycles each input sample is held; must be >= 1
// PORTS
//  clk        in   1            system clock (same clk as filter)
//  rst        in   1            reset, synchronous, active-high
//  u_in       in   n_int+n_mant+1  signed input sample, Q(n_int).(n_mant)
//  u_valid    in   1            u_in valid
//  u_ready    out  1            block accepts u_in this cycle
//  ctrl_out   out  N            control bits s[N-1:0]; bit n is integrator n
//  ctrl_valid out  1            ctrl_out carries a modulator decision
//  overflow   out  1            sticky: some integrator saturated
//  underrun   out  1            sticky: hold expired with no new sample
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE; x[n]=0; hold_cnt=0; u_hold=0.
//   Output reset values: ctrl_out=0, ctrl_valid=0, overflow=0, underrun=0, u_ready=0.
//   u_ready goes to 1 combinationally in IDLE once rst=0.
//  FSM states: IDLE, RUN.
//   IDLE: u_ready=1. On u_valid: latch u_hold=u_in, set hold_cnt=0, go to RUN.
//    Integrators are frozen in IDLE.
//   RUN: integrators update every clk. u_ready=1 only when hold_cnt==HOLD-1.
//    At hold_cnt==HOLD-1 with u_valid: load the new sample and set hold_cnt=0.
//    At hold_cnt==HOLD-1 without u_valid: keep u_hold, set hold_cnt=0, set underrun=1.
//    Otherwise: hold_cnt++.
//    RUN exits only via rst.
//  HOLD==1: u_ready is constantly 1 in RUN.
//  Decision: s[n] = ~x[n][MSB] (1 when x>=0), evaluated on the current x.
//  Update (RUN), all in width W=n_int+n_mant+1 with K = 2^(n_mant-BETA_SHIFT):
//   x[0] <= sat(x[0] + (u_hold >>> BETA_SHIFT) - (s[0] ? K : -K))
//   x[n] <= sat(x[n] + (x[n-1] >>> BETA_SHIFT) - (s[n] ? K : -K)), for n>=1, using old x[n-1]
//   Compute the sum in W+2 bits, then clamp to [-2^(W-1), 2^(W-1)-1]. Any clamp sets overflow=1.
//  Timing: ctrl_out <= s and ctrl_valid <= 1 are registered in the same cycle as the update.
//   ctrl_out therefore lags x by one clk. The first ctrl_valid=1 is the cycle after IDLE->RUN.
//  Sticky flags are cleared only by rst.
//  Reset mid-RUN: the next cycle is exactly the reset state. Any in-flight sample is dropped.
// STRUCTURE
//  Package cbadc_mod_p holds:
//   typedef enum {IDLE, RUN} mod_state_t;
//   function sat_w(): the width-generic clamp function;
//   localparam K computation.
//  Sub-module fix_integrator_stage(clk, rst, en, x_in, s, x, sat):
//   one integrator with shift, subtract and saturate. Instantiated N times in a generate loop.
//  The top level holds the FSM, hold counter, u_hold register, output registers and flags.
// TESTING
//  1. rst=1 for 3 cycles -> ctrl_out=0, ctrl_valid=0, overflow=0, underrun=0; u_ready=1 after release.
//  2. u_in=0 held, valid always -> ctrl_out[0] = 1,0,1,0,... from the first valid cycle; x[0] in {0,-K}.
//  3. HOLD=12, u_valid always 1 -> u_ready pulses exactly once per 12 clk in RUN; one sample accepted per pulse.
//  4. u_valid deasserted across one hold boundary -> underrun=1; the previous sample is reused; no spurious ctrl_valid drop.
//  5. u_in=+4.0 (4<<n_mant) constant -> x[0] rises by 3K per cycle to 2^(W-1)-1 and clamps; overflow=1.
//     rst -> overflow=0.
//  6. Loop-back: 1 kHz-normalised sine at 0.5 FS into this block, ctrl_out -> filter in with rst inverted.
//     Expect filter output to match the input sine within 60 dB SNR once the filter asserts valid.

Source files
------------

// File: rtl/cbadc_modulator_fix_pkg.sv
// cbadc_mod_p: shared types, default parameters and helpers for the
// chain-of-integrators control-bounded ADC modulator.
//   mod_state_t : modulator FSM states (IDLE, RUN)
//   k_val()     : control step K = 2^(n_mant - beta_shift)
//   sat_w()     : width-generic two's-complement clamp
package cbadc_mod_p;

  localparam int N_DEF          = 3;
  localparam int N_INT_DEF      = 9;
  localparam int N_MANT_DEF     = 15;
  localparam int BETA_SHIFT_DEF = 3;
  localparam int HOLD_DEF       = 12;
  localparam int W_DEF          = N_INT_DEF + N_MANT_DEF + 1;

  typedef enum logic {IDLE, RUN} mod_state_t;

  // Control feedback magnitude: full scale scaled by the integrator gain.
  function automatic longint k_val(input int n_mant, input int beta_shift);
    k_val = longint'(1) << (n_mant - beta_shift);
  endfunction

  localparam longint K_DEF = k_val(N_MANT_DEF, BETA_SHIFT_DEF);

  // Clamp v into the signed range of a w-bit word. Callers keep w+2 <= 64
  // so the unclamped sum always fits the longint argument.
  function automatic longint sat_w(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (v > hi)
      sat_w = hi;
    else if (v < lo)
      sat_w = lo;
    else
      sat_w = v;
  endfunction

endpackage

// File: rtl/cbadc_modulator_fix_if.sv
// Stream interface of the modulator.
//   u_in/u_valid/u_ready : sample input stream (ready/valid)
//   ctrl_out/ctrl_valid  : control-bit output stream to the CB filter
//   overflow/underrun    : sticky status flags
// modport slave is the modulator side, modport master the driving side.
interface cbadc_modulator_fix_if
  import cbadc_mod_p::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  logic signed [W-1:0] u_in;
  logic                u_valid;
  logic                u_ready;
  logic [N-1:0]        ctrl_out;
  logic                ctrl_valid;
  logic                overflow;
  logic                underrun;

  modport master (
    output u_in, u_valid,
    input  u_ready, ctrl_out, ctrl_valid, overflow, underrun
  );

  modport slave (
    input  u_in, u_valid,
    output u_ready, ctrl_out, ctrl_valid, overflow, underrun
  );
endinterface

// File: rtl/cbadc_modulator_fix_stage.sv
// fix_integrator_stage: one saturating integrator of the modulator chain.
//   clk, rst : clock, synchronous active-high reset
//   en       : update enable (integrator frozen when low)
//   x_in     : upstream signal (held sample or previous integrator state)
//   s        : control decision, 1 when x >= 0
//   x        : integrator state
//   sat      : this cycle's update is being clamped (only when en)
module fix_integrator_stage
  import cbadc_mod_p::*;
#(
  parameter int     W          = W_DEF,
  parameter int     BETA_SHIFT = BETA_SHIFT_DEF,
  parameter longint K          = K_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] x_in,
  output logic                s,
  output logic signed [W-1:0] x,
  output logic                sat
);

  localparam logic signed [W+1:0] K_EXT = (W+2)'(K);

  logic signed [W-1:0] x_reg;
  logic signed [W-1:0] x_next;
  logic signed [W-1:0] x_in_shifted;
  logic signed [W+1:0] sum;
  longint              sum_wide;
  longint              sum_clamped;

  assign x_in_shifted = x_in >>> BETA_SHIFT;
  assign s            = ~x_reg[W-1];
  assign x            = x_reg;

  // Two guard bits hold state + input + feedback without wrap before the clamp.
  always_comb begin
    sum = $signed({{2{x_reg[W-1]}}, x_reg})
        + $signed({{2{x_in_shifted[W-1]}}, x_in_shifted})
        - (s ? K_EXT : -K_EXT);
    sum_wide    = longint'(sum);
    sum_clamped = sat_w(sum_wide, W);
    x_next      = sum_clamped[W-1:0];
    sat         = en && (sum_clamped != sum_wide);
  end

  always_ff @(posedge clk) begin
    if (rst)
      x_reg <= '0;
    else if (en)
      x_reg <= x_next;
  end

endmodule

// File: rtl/cbadc_modulator_fix.sv
// cbadc_modulator_fix: bit-true chain-of-integrators control-bounded ADC
// modulator with zero-order hold of HOLD cycles on each input sample.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of cbadc_modulator_fix_if
//              (u_in/u_valid/u_ready in, ctrl_out/ctrl_valid out,
//               sticky overflow/underrun flags)
module cbadc_modulator_fix
  import cbadc_mod_p::*;
#(
  parameter int N          = N_DEF,
  parameter int N_INT      = N_INT_DEF,
  parameter int N_MANT     = N_MANT_DEF,
  parameter int BETA_SHIFT = BETA_SHIFT_DEF,
  parameter int HOLD       = HOLD_DEF
) (
  input logic                 clk,
  input logic                 rst,
  cbadc_modulator_fix_if.slave bus
);

  localparam int                W         = N_INT + N_MANT + 1;
  localparam longint            K         = k_val(N_MANT, BETA_SHIFT);
  localparam int                HC_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD - 1);

  mod_state_t          state_reg;
  logic [HC_W-1:0]     hold_cnt_reg;
  logic signed [W-1:0] u_hold_reg;
  logic [N-1:0]        ctrl_reg;
  logic                ctrl_valid_reg;
  logic                overflow_reg;
  logic                underrun_reg;

  logic                run_en;
  logic                hold_last;
  logic [N-1:0]        s_vec;
  logic [N-1:0]        sat_vec;
  logic signed [W-1:0] x_arr [N];

  assign run_en    = (state_reg == RUN);
  assign hold_last = (hold_cnt_reg == HOLD_LAST);

  // Integrator chain: stage 0 integrates the held sample, stage n the
  // previous-cycle state of stage n-1.
  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    logic signed [W-1:0] stage_in;
    if (gi == 0) begin : g_first
      assign stage_in = u_hold_reg;
    end else begin : g_next
      assign stage_in = x_arr[gi-1];
    end
    fix_integrator_stage #(
      .W(W), .BETA_SHIFT(BETA_SHIFT), .K(K)
    ) u_stage (
      .clk(clk), .rst(rst), .en(run_en), .x_in(stage_in),
      .s(s_vec[gi]), .x(x_arr[gi]), .sat(sat_vec[gi])
    );
  end

  // The last integrator's state drives only its own decision bit.
  logic unused_tail;
  assign unused_tail = &{1'b0, x_arr[N-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      hold_cnt_reg   <= '0;
      u_hold_reg     <= '0;
      ctrl_reg       <= '0;
      ctrl_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.u_valid) begin
            u_hold_reg   <= bus.u_in;
            hold_cnt_reg <= '0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          // Decision of the current x goes out with the update: ctrl lags x by one clk.
          ctrl_reg       <= s_vec;
          ctrl_valid_reg <= 1'b1;
          if (|sat_vec)
            overflow_reg <= 1'b1;
          if (hold_last) begin
            hold_cnt_reg <= '0;
            if (bus.u_valid)
              u_hold_reg <= bus.u_in;
            else
              underrun_reg <= 1'b1;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HC_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.u_ready    = ~rst & ((state_reg == IDLE) | ((state_reg == RUN) & hold_last));
  assign bus.ctrl_out   = ctrl_reg;
  assign bus.ctrl_valid = ctrl_valid_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.underrun   = underrun_reg;

endmodule

// File: tb/tb_cbadc_modulator_fix.sv
module tb_cbadc_modulator_fix;

  localparam int     N    = 3;
  localparam int     W    = 25;
  localparam int     HOLD = 12;
  localparam int     BS   = 3;
  localparam longint K    = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cbadc_modulator_fix_if #(.N(N), .W(W)) bus ();

  cbadc_modulator_fix #(
    .N(N), .N_INT(9), .N_MANT(15), .BETA_SHIFT(BS), .HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic         m_run;
  int           m_hc;
  longint       m_uh;
  longint       m_x [N];
  logic [N-1:0] m_ctrl;
  logic         m_cv, m_ovf, m_und;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input longint u);
    longint       xn [N];
    longint       src, sum, hi, lo;
    logic [N-1:0] s;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (r) begin
      m_run = 1'b0; m_hc = 0; m_uh = 0; m_ctrl = '0;
      m_cv = 1'b0; m_ovf = 1'b0; m_und = 1'b0;
      for (int n = 0; n < N; n++) m_x[n] = 0;
    end else if (!m_run) begin
      if (v) begin
        m_run = 1'b1; m_uh = u; m_hc = 0;
      end
    end else begin
      for (int n = 0; n < N; n++) s[n] = (m_x[n] >= 0);
      for (int n = 0; n < N; n++) begin
        if (n == 0) src = m_uh; else src = m_x[n-1];
        sum = m_x[n] + (src >>> BS) + (s[n] ? -K : K);
        if (sum > hi) begin xn[n] = hi; m_ovf = 1'b1; end
        else if (sum < lo) begin xn[n] = lo; m_ovf = 1'b1; end
        else xn[n] = sum;
      end
      for (int n = 0; n < N; n++) m_x[n] = xn[n];
      m_ctrl = s;
      m_cv   = 1'b1;
      if (m_hc == HOLD - 1) begin
        m_hc = 0;
        if (v) m_uh = u; else m_und = 1'b1;
      end else begin
        m_hc++;
      end
    end
  endtask

  // Apply inputs for one clock; returns at the following negedge.
  task automatic drive(input logic r, input logic v, input longint u);
    rst         = r;
    bus.u_valid = v;
    bus.u_in    = u[W-1:0];
    model_step(r, v, u);
    @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    logic m_ready;
    m_ready = !rst && (!m_run || (m_hc == HOLD - 1));
    check({tag, ".ctrl_out"},   longint'(bus.ctrl_out),   longint'(m_ctrl));
    check({tag, ".ctrl_valid"}, longint'(bus.ctrl_valid), longint'(m_cv));
    check({tag, ".overflow"},   longint'(bus.overflow),   longint'(m_ovf));
    check({tag, ".underrun"},   longint'(bus.underrun),   longint'(m_und));
    check({tag, ".u_ready"},    longint'(bus.u_ready),    longint'(m_ready));
  endtask

  typedef struct {
    logic         r;
    logic         v;
    longint       u;
    logic [N-1:0] e_ctrl;
    logic         e_cv;
    logic         e_ready;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int     pulses;
    int     first_ovf;
    logic   found;
    longint u;

    // Reset for three cycles, release, then u_in=0 with valid held high.
    // Expected control words are worked out by hand from the update rule.
    vecs[0]  = '{1'b1, 1'b0, 64'sd0, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 64'sd0, 3'b000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 64'sd0, 3'b000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 64'sd0, 3'b000, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 64'sd0, 3'b000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 64'sd0, 3'b111, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 64'sd0, 3'b000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 64'sd0, 3'b001, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 64'sd0, 3'b110, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 64'sd0, 3'b001, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 64'sd0, 3'b110, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 64'sd0, 3'b101, 1'b1, 1'b0};

    bus.u_valid = 1'b0;
    bus.u_in    = '0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].u);
      $display("vec %0d: rst=%0b valid=%0b -> ctrl=%b cv=%0b ready=%0b", i,
               vecs[i].r, vecs[i].v, bus.ctrl_out, bus.ctrl_valid, bus.u_ready);
      check($sformatf("vec%0d.ctrl_out", i),   longint'(bus.ctrl_out),   longint'(vecs[i].e_ctrl));
      check($sformatf("vec%0d.ctrl_valid", i), longint'(bus.ctrl_valid), longint'(vecs[i].e_cv));
      check($sformatf("vec%0d.u_ready", i),    longint'(bus.u_ready),    longint'(vecs[i].e_ready));
      check($sformatf("vec%0d.overflow", i),   longint'(bus.overflow),   0);
      check($sformatf("vec%0d.underrun", i),   longint'(bus.underrun),   0);
    end

    // Hold cadence: cycle k of RUN (k=1 first) has hold_cnt=k-1, so ready
    // pulses on k = 12, 24, 36, 48. Input changes every cycle; only the
    // sample presented on a pulse may be taken.
    pulses = 0;
    for (int k = 9; k <= 56; k++) begin
      u = longint'(k) * 3001 - 70000;
      drive(1'b0, 1'b1, u);
      if (bus.u_ready) pulses++;
      check($sformatf("cad%0d.u_ready", k), longint'(bus.u_ready), longint'(k % 12 == 0));
      compare_model($sformatf("cad%0d", k));
    end
    check("cadence.pulses", pulses, 4);
    $display("cadence: %0d ready pulses in 48 cycles", pulses);

    // Underrun: let one hold boundary pass with u_valid low.
    found = 1'b0;
    for (int i = 0; i < 2 * HOLD; i++) begin
      if (bus.u_ready) begin found = 1'b1; break; end
      drive(1'b0, 1'b1, 64'sd25000);
    end
    check("underrun.ready_wait", longint'(found), 1);
    check("underrun.before", longint'(bus.underrun), 0);
    drive(1'b0, 1'b0, -64'sd99999);
    $display("underrun: boundary without valid -> underrun=%0b cv=%0b", bus.underrun, bus.ctrl_valid);
    check("underrun.flag", longint'(bus.underrun), 1);
    check("underrun.ctrl_valid", longint'(bus.ctrl_valid), 1);
    compare_model("underrun.edge");
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1, longint'(i) * 5003 - 60000);
      check($sformatf("reuse%0d.ctrl_valid", i), longint'(bus.ctrl_valid), 1);
      compare_model($sformatf("reuse%0d", i));
    end

    // Reset mid-RUN returns exactly to the reset state.
    drive(1'b1, 1'b1, 64'sd12345);
    $display("midrst: ctrl=%b cv=%0b ovf=%0b und=%0b ready=%0b", bus.ctrl_out,
             bus.ctrl_valid, bus.overflow, bus.underrun, bus.u_ready);
    check("midrst.ctrl_out", longint'(bus.ctrl_out), 0);
    check("midrst.ctrl_valid", longint'(bus.ctrl_valid), 0);
    check("midrst.underrun", longint'(bus.underrun), 0);
    check("midrst.overflow", longint'(bus.overflow), 0);
    check("midrst.u_ready", longint'(bus.u_ready), 0);
    drive(1'b0, 1'b0, 64'sd0);
    check("midrst.idle_ready", longint'(bus.u_ready), 1);
    check("midrst.idle_cv", longint'(bus.ctrl_valid), 0);

    // +4.0 full scale: x[0] climbs by 3K per cycle and every stage clamps.
    first_ovf = -1;
    for (int i = 0; i < 1500; i++) begin
      drive(1'b0, 1'b1, longint'(4) <<< 15);
      if (first_ovf < 0 && bus.overflow) first_ovf = i;
      compare_model($sformatf("ovf%0d", i));
    end
    $display("overflow: first set at cycle %0d of saturation run", first_ovf);
    check("ovf.sticky", longint'(bus.overflow), 1);
    check("ovf.ctrl_out", longint'(bus.ctrl_out), 7);
    check("ovf.ctrl_valid", longint'(bus.ctrl_valid), 1);
    drive(1'b1, 1'b0, 64'sd0);
    check("ovf.rst_clear", longint'(bus.overflow), 0);
    check("ovf.rst_cv", longint'(bus.ctrl_valid), 0);
    drive(1'b0, 1'b0, 64'sd0);
    check("ovf.after_rst", longint'(bus.overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
